// File: rtl/mem_bus_arbiter.sv
// Two-master, single-slave memory bus arbiter with round-robin tie-break,
// latched transaction request and a per-transaction slave watchdog.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_rd_en_i,
    input  logic        m0_wr_en_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_rd_en_i,
    input  logic        m1_wr_en_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_rd_en_o,
    output logic        s_wr_en_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic        owner_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Last watchdog count before the error ack fires; clamped so TIMEOUT_CYCLES=0 stays legal.
    localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_r;
    logic              owner_r;
    logic              last_owner_r;
    logic              req_wr_r;
    logic [31:0]       req_addr_r;
    logic [31:0]       req_data_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              m0_req_s;
    logic              m1_req_s;
    logic              winner_s;
    logic              ack_s;
    logic              timeout_s;
    logic              done_s;
    logic [31:0]       rdata_s;

    // Request decode, round-robin winner selection and completion qualifiers.
    always_comb begin
        m0_req_s  = m0_rd_en_i | m0_wr_en_i;
        m1_req_s  = m1_rd_en_i | m1_wr_en_i;
        winner_s  = 1'b0;
        if (m0_req_s && m1_req_s) begin
            winner_s = ~last_owner_r;
        end else if (m1_req_s) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        ack_s     = (state_r == ST_BUSY) && s_ack_i;
        // A slave ack in the timeout cycle wins, so the watchdog only fires without one.
        timeout_s = (TIMEOUT_CYCLES != 0) && (state_r == ST_BUSY) && !s_ack_i && (cnt_r == TO_LAST);
        done_s    = ack_s | timeout_s;
        if (ack_s && !req_wr_r) begin
            rdata_s = s_data_i;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Arbiter state machine: grant, latch the winner's request and run the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            req_wr_r     <= 1'b0;
            req_addr_r   <= 32'h0000_0000;
            req_data_r   <= 32'h0000_0000;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_req_s || m1_req_s) begin
                        state_r      <= ST_BUSY;
                        owner_r      <= winner_s;
                        last_owner_r <= winner_s;
                        req_wr_r     <= winner_s ? m1_wr_en_i : m0_wr_en_i;
                        req_addr_r   <= winner_s ? m1_addr_i  : m0_addr_i;
                        req_data_r   <= winner_s ? m1_data_i  : m0_data_i;
                        cnt_r        <= {CNT_W{1'b0}};
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave side comes straight from the latched request; master side only to the owner.
    always_comb begin
        busy_o    = (state_r == ST_BUSY);
        owner_o   = owner_r;
        s_rd_en_o = 1'b0;
        s_wr_en_o = 1'b0;
        s_addr_o  = 32'h0000_0000;
        s_data_o  = 32'h0000_0000;
        if (state_r == ST_BUSY) begin
            s_rd_en_o = ~req_wr_r;
            s_wr_en_o = req_wr_r;
            s_addr_o  = req_addr_r;
            s_data_o  = req_data_r;
        end else begin
            s_rd_en_o = 1'b0;
        end
        m0_ack_o  = done_s & ~owner_r;
        m0_err_o  = timeout_s & ~owner_r;
        m0_data_o = owner_r ? 32'h0000_0000 : rdata_s;
        m1_ack_o  = done_s & owner_r;
        m1_err_o  = timeout_s & owner_r;
        m1_data_o = owner_r ? rdata_s : 32'h0000_0000;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_rd_en_i = 1'b0, m0_wr_en_i = 1'b0;
    logic [31:0] m0_addr_i = 32'h0, m0_data_i = 32'h0;
    logic [31:0] m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_rd_en_i = 1'b0, m1_wr_en_i = 1'b0;
    logic [31:0] m1_addr_i = 32'h0, m1_data_i = 32'h0;
    logic [31:0] m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_rd_en_o, s_wr_en_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [31:0] s_data_i = 32'h0;
    logic        s_ack_i = 1'b0;
    logic        owner_o, busy_o;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_rd_en_i(m0_rd_en_i), .m0_wr_en_i(m0_wr_en_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_rd_en_i(m1_rd_en_i), .m1_wr_en_i(m1_wr_en_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_rd_en_o(s_rd_en_o), .s_wr_en_o(s_wr_en_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .owner_o(owner_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: one in-flight transaction record plus its age in BUSY cycles.
    bit        mdl_busy  = 1'b0;
    bit        mdl_owner = 1'b0;
    bit        mdl_last  = 1'b1;
    bit        mdl_wr    = 1'b0;
    bit [31:0] mdl_addr  = 32'h0;
    bit [31:0] mdl_data  = 32'h0;
    int        mdl_age   = 0;
    bit        grant_log [0:63];
    int        gcnt      = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_busy  <= 1'b0;
            mdl_owner <= 1'b0;
            mdl_last  <= 1'b1;
            mdl_wr    <= 1'b0;
            mdl_addr  <= 32'h0;
            mdl_data  <= 32'h0;
            mdl_age   <= 0;
        end else if (!mdl_busy) begin
            bit r0, r1, w;
            r0 = m0_rd_en_i || m0_wr_en_i;
            r1 = m1_rd_en_i || m1_wr_en_i;
            if (r0 || r1) begin
                w = (r0 && r1) ? !mdl_last : r1;
                mdl_busy  <= 1'b1;
                mdl_owner <= w;
                mdl_last  <= w;
                mdl_wr    <= w ? m1_wr_en_i : m0_wr_en_i;
                mdl_addr  <= w ? m1_addr_i : m0_addr_i;
                mdl_data  <= w ? m1_data_i : m0_data_i;
                mdl_age   <= 0;
                grant_log[gcnt] <= w;
                gcnt      <= gcnt + 1;
            end
        end else begin
            if (s_ack_i || (mdl_age == TO - 1)) mdl_busy <= 1'b0;
            else mdl_age <= mdl_age + 1;
        end
    end

    int m0_pulses = 0;
    int m1_pulses = 0;

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit        e_ack, e_to, e_done;
        bit [31:0] e_rd;
        e_ack  = mdl_busy && s_ack_i;
        e_to   = mdl_busy && !s_ack_i && (TO != 0) && (mdl_age == TO - 1);
        e_done = e_ack || e_to;
        e_rd   = (e_ack && !mdl_wr) ? s_data_i : 32'h0;
        chk("busy", busy_o, mdl_busy);
        chk("owner", owner_o, mdl_owner);
        chk("s_rd_en", s_rd_en_o, mdl_busy && !mdl_wr);
        chk("s_wr_en", s_wr_en_o, mdl_busy && mdl_wr);
        chk("s_addr", s_addr_o, mdl_busy ? mdl_addr : 32'h0);
        chk("s_data", s_data_o, mdl_busy ? mdl_data : 32'h0);
        chk("m0_ack", m0_ack_o, e_done && !mdl_owner);
        chk("m0_err", m0_err_o, e_to && !mdl_owner);
        chk("m0_data", m0_data_o, mdl_owner ? 32'h0 : e_rd);
        chk("m1_ack", m1_ack_o, e_done && mdl_owner);
        chk("m1_err", m1_err_o, e_to && mdl_owner);
        chk("m1_data", m1_data_o, mdl_owner ? e_rd : 32'h0);
        if (m0_ack_o) m0_pulses++;
        if (m1_ack_o) m1_pulses++;
    end

    // Slave responder: ack in the slave_lat-th BUSY cycle (0 = never).
    int        slave_lat = 1;
    int        sl_age    = 0;
    logic [31:0] rd_word = 32'h0;
    bit        m0_drop = 1'b1, m1_drop = 1'b1;

    task automatic tick();
        logic a0, a1;
        @(negedge clk);
        a0 = m0_ack_o;
        a1 = m1_ack_o;
        @(posedge clk);
        #1;
        if (busy_o) sl_age = sl_age + 1;
        else sl_age = 0;
        s_ack_i  = (slave_lat != 0) && busy_o && (sl_age == slave_lat);
        s_data_i = rd_word;
        if (m0_drop && a0) begin m0_rd_en_i = 1'b0; m0_wr_en_i = 1'b0; end
        if (m1_drop && a1) begin m1_rd_en_i = 1'b0; m1_wr_en_i = 1'b0; end
    endtask

    initial begin
        int p0, p1, g0;
        bit exp_order [0:5];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_owner", owner_o, 1'b0);
        chk("rst_s_rd", s_rd_en_o, 1'b0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        rst = 1'b0;
        tick();

        // Both masters read at once, slave acks in the first BUSY cycle.
        p0 = m0_pulses; p1 = m1_pulses; g0 = gcnt;
        rd_word = 32'h1234_5678; slave_lat = 1;
        m0_addr_i = 32'h0000_0010; m1_addr_i = 32'h0000_0020;
        m0_rd_en_i = 1'b1; m1_rd_en_i = 1'b1;
        tick(); #1;
        chk("t1_busy_a", busy_o, 1'b1);
        chk("t1_owner_a", owner_o, 1'b0);
        chk("t1_m0_data", m0_data_o, 32'h1234_5678);
        tick();
        chk("t1_bubble", busy_o, 1'b0);
        tick(); #1;
        chk("t1_owner_b", owner_o, 1'b1);
        chk("t1_m1_data", m1_data_o, 32'h1234_5678);
        repeat (2) tick();
        chk("t1_m0_pulses", m0_pulses - p0, 1);
        chk("t1_m1_pulses", m1_pulses - p1, 1);
        chk("t1_order0", grant_log[g0], 1'b0);
        chk("t1_order1", grant_log[g0 + 1], 1'b1);

        // Slave never acks: error ack in the 4th BUSY cycle.
        slave_lat = 0; rd_word = 32'hCAFE_F00D;
        m0_addr_i = 32'h0000_0040; m0_rd_en_i = 1'b1;
        repeat (4) tick();
        #1;
        chk("t3_ack", m0_ack_o, 1'b1);
        chk("t3_err", m0_err_o, 1'b1);
        chk("t3_data", m0_data_o, 32'h0);
        tick();
        chk("t3_idle", busy_o, 1'b0);
        tick();

        // m1 write, request withdrawn mid-transaction, ack in the 3rd BUSY cycle.
        p0 = m0_pulses; p1 = m1_pulses;
        slave_lat = 3;
        m1_addr_i = 32'h0000_0100; m1_data_i = 32'hDEAD_BEEF; m1_wr_en_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            chk("t2_addr", s_addr_o, 32'h0000_0100);
            chk("t2_data", s_data_o, 32'hDEAD_BEEF);
            chk("t2_wr", s_wr_en_o, 1'b1);
            if (c == 1) begin
                m1_wr_en_i = 1'b0; m1_addr_i = 32'h0000_FFFF; m1_data_i = 32'h0;
            end
        end
        chk("t2_ack", m1_ack_o, 1'b1);
        chk("t2_wdata0", m1_data_o, 32'h0);
        repeat (2) tick();
        chk("t2_m1_pulses", m1_pulses - p1, 1);
        chk("t2_m0_pulses", m0_pulses - p0, 0);

        // Both masters hold requests for 6 transactions.
        g0 = gcnt; slave_lat = 1; m0_drop = 1'b0; m1_drop = 1'b0;
        m0_addr_i = 32'h0000_0200; m1_addr_i = 32'h0000_0300; m1_data_i = 32'h0BAD_F00D;
        m0_rd_en_i = 1'b1; m1_wr_en_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ((i % 2) == 0) chk("t4_owner", owner_o, i / 2 % 2);
        end
        m0_rd_en_i = 1'b0; m1_wr_en_i = 1'b0;
        m0_drop = 1'b1; m1_drop = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) chk("t4_order", grant_log[g0 + i], exp_order[i]);
        chk("t4_count", gcnt - g0, 6);

        // Read and write enable together means a write.
        m0_addr_i = 32'h0000_0400; m0_data_i = 32'h5555_AAAA;
        m0_rd_en_i = 1'b1; m0_wr_en_i = 1'b1;
        tick(); #1;
        chk("t6_wr", s_wr_en_o, 1'b1);
        chk("t6_rd", s_rd_en_o, 1'b0);
        repeat (2) tick();

        // Reset while BUSY aborts silently; tie after reset goes to m0.
        p0 = m0_pulses; p1 = m1_pulses;
        slave_lat = 0;
        m0_rd_en_i = 1'b1; m1_rd_en_i = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_s_rd", s_rd_en_o, 1'b0);
        chk("t5_busy", busy_o, 1'b0);
        tick();
        chk("t5_no_ack", (m0_pulses - p0) + (m1_pulses - p1), 0);
        rst = 1'b0;
        slave_lat = 1;
        tick(); #1;
        chk("t5_grant", owner_o, 1'b0);
        chk("t5_busy2", busy_o, 1'b1);
        repeat (5) tick();
        m0_rd_en_i = 1'b0; m1_rd_en_i = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, single-slave memory bus arbiter for the multicycle core's memory bus. It shares one memory port between master 0 (the core) and master 1 (loader/DMA/debug), using round-robin arbitration and a level request / single-cycle ack handshake. Each granted transaction's request is latched, so the slave sees stable signals. A per-transaction watchdog releases the bus if the slave never acks.

## Interface
- `TIMEOUT_CYCLES`, default 16: BUSY cycles without `s_ack_i` before an error ack. 0 disables the watchdog.
- `CNT_W`, default 8: watchdog counter width. Must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `m0_rd_en_i`, `m0_wr_en_i`  in  1 each: master 0 read/write request (level).
- `m0_addr_i`, `m0_data_i`  in  32 each: master 0 address and write data.
- `m0_data_o`  out  32: master 0 read data, valid only while `m0_ack_o` is 1.
- `m0_ack_o`  out  1: master 0 transaction complete (1-cycle pulse).
- `m0_err_o`  out  1: qualifies `m0_ack_o`; 1 means timeout.
- `m1_*`: identical set for master 1.
- `s_rd_en_o`, `s_wr_en_o`  out  1 each: slave read/write strobe.
- `s_addr_o`, `s_data_o`  out  32 each: slave address and write data.
- `s_data_i`  in  32: slave read data.
- `s_ack_i`  in  1: slave completion.
- `owner_o`  out  1: current/last granted master.
- `busy_o`  out  1: transaction in flight.

## Operation
- States: IDLE and BUSY. Registers: `owner`, `last_owner`, `req_wr`, `req_addr`, `req_data`, `cnt`.
- A master requests when `rd_en | wr_en` is 1. If both are 1, the transaction is a write.
- Master contract: hold the request, address and data stable until its ack.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one master requesting: grant that master.
- IDLE, both requesting: grant `!last_owner` (round-robin).
- On grant:
  - latch op/addr/data from the winner;
  - set `owner` and `last_owner` to the winner;
  - clear `cnt`;
  - go to BUSY.
- BUSY, slave outputs: driven from the latched registers. `s_wr_en_o` = `req_wr`, `s_rd_en_o` = `!req_wr`.
- BUSY, `s_ack_i` = 1:
  - owner's `ack_o` = 1, `err_o` = 0;
  - owner's `data_o` = `s_data_i` (combinational pass-through; 0 for writes);
  - next state IDLE.
- BUSY, no ack, `TIMEOUT_CYCLES` ≠ 0 and `cnt == TIMEOUT_CYCLES-1`:
  - owner's `ack_o` = 1, `err_o` = 1, `data_o` = 0;
  - next state IDLE.
- BUSY, otherwise: `cnt` increments (saturating).
- Request withdrawn during BUSY: the transaction still completes on the slave side. The ack pulse is still issued; the master ignores it.
- Non-owner: `ack_o`, `err_o` and `data_o` are always 0.
- `s_ack_i` while in IDLE: ignored.
- `busy_o` = (state == BUSY). `owner_o` = `owner`.

## Timing
- Reset (async, immediate):
  - state IDLE, `owner` = 0, `last_owner` = 1, `cnt` = 0, `req_*` = 0;
  - all `s_*_o`, `m*_ack_o`, `m*_err_o`, `m*_data_o` = 0;
  - `busy_o` = 0, `owner_o` = 0.
- Request visible in IDLE at edge N → BUSY from N+1. Slave strobes asserted during cycle N+1.
- `s_ack_i` in cycle M → master ack in the same cycle M (zero added latency). Slave strobes drop at M+1.
- Minimum transaction: 2 cycles (grant, ack). Back-to-back requests leave one IDLE bubble (re-arbitration) between transactions.
- Timeout ack occurs in the `TIMEOUT_CYCLES`-th BUSY cycle.
- `s_ack_i` arriving in the same cycle as the timeout: treated as a normal ack (`err` = 0).
- Reset mid-BUSY: the transaction is aborted with no ack pulse. The first grant after reset goes to master 0 on a tie.

## Test plan
- Reset, then both masters request reads simultaneously; slave acks the cycle after each grant.
  - Required: grants m0 then m1.
  - `m0_ack_o` and `m1_ack_o` each pulse once, with `s_data_i` returned.
  - One IDLE cycle between the two transactions.
- m1 write, addr 0x100, data 0xDEADBEEF; master deasserts mid-transaction; slave acks 3 cycles after grant.
  - Required: `s_addr_o` = 0x100 and `s_data_o` = 0xDEADBEEF stable for all 3 BUSY cycles; `s_wr_en_o` = 1.
  - `m1_ack_o` pulses once; `m0_ack_o` stays 0.
- Slave never acks, `TIMEOUT_CYCLES` = 4.
  - Required: after the 4th BUSY cycle, `m0_ack_o` = 1, `m0_err_o` = 1, `m0_data_o` = 0; arbiter returns to IDLE.
- Both masters hold requests continuously for 6 transactions.
  - Required: grant order 0,1,0,1,0,1.
- Assert `rst` while BUSY.
  - Required: `s_rd_en_o` = 0 immediately, no ack pulse.
  - After release with a tie, m0 is granted first.
- `m0_rd_en_i` and `m0_wr_en_i` both 1.
  - Required: `s_wr_en_o` = 1, `s_rd_en_o` = 0.
